// File: rtl/time_setter.sv
// Button-driven hh:mm:ss entry for the digital clock: capture, step fields, commit with a one-cycle strobe.
// Optional hold-to-repeat stepping is enabled by defining TIME_SETTER_AUTOREPEAT_EN.
module time_setter #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [23:0] REPEAT_DELAY    = 24'd5000000,
    parameter logic [23:0] REPEAT_RATE     = 24'd1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic [16:0] cur_time,
    output logic [16:0] time_out,
    output logic        time_ow,
    output logic        editing,
    output logic [1:0]  edit_field,
    output logic [16:0] edit_time
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOUR,
        S_MIN,
        S_SEC,
        S_COMMIT
    } state_t;

    state_t state, state_d;

    logic [2:0]       btn_raw;
    logic [2:0]       sync_p0, sync_p1;
    logic [2:0]       level, level_prev;
    logic [2:0][15:0] db_cnt;
    logic [2:0]       press;
    logic             mode_press, inc_press, dec_press;
    logic             inc_step, dec_step;

    logic [4:0]  hour_q, hour_d;
    logic [5:0]  min_q, min_d;
    logic [5:0]  sec_q, sec_d;
    logic [16:0] time_out_q, time_out_d;
    logic [5:0]  hour_step, min_step, sec_step;

    // Wrapping step of one field; simultaneous up and down cancel.
    function automatic logic [5:0] step_field(input logic [5:0] v, input logic [5:0] top,
                                              input logic up, input logic dn);
        if (up && !dn)
            return (v >= top) ? 6'd0 : v + 6'd1;
        else if (dn && !up)
            return (v == 6'd0 || v > top) ? top : v - 6'd1;
        else
            return v;
    endfunction

    assign btn_raw = {btn_dec, btn_inc, btn_mode};

    // Synchronizer stages feeding per-button debounce counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0    <= '0;
            sync_p1    <= '0;
            level      <= '0;
            level_prev <= '0;
            db_cnt     <= '0;
        end else begin
            sync_p0    <= btn_raw;
            sync_p1    <= sync_p0;
            level_prev <= level;
            for (int i = 0; i < 3; i++) begin
                if (sync_p1[i] != level[i]) begin
                    if (db_cnt[i] == DEBOUNCE_CYCLES - 16'd1) begin
                        level[i]  <= sync_p1[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 16'd1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign press      = level & ~level_prev;
    assign mode_press = press[0];
    assign inc_press  = press[1];
    assign dec_press  = press[2];

`ifdef TIME_SETTER_AUTOREPEAT_EN
    logic [23:0] rpt_cnt;
    logic        rpt_armed;
    logic        hold;
    logic        rpt_fire;

    // Counter restarts whenever the hold is broken: release, both held, mode press or leaving edit.
    assign hold = editing && (level[1] ^ level[2]) && !mode_press;

    always_comb begin
        rpt_fire = 1'b0;
        if (hold)
            rpt_fire = rpt_armed ? (rpt_cnt == REPEAT_RATE) : (rpt_cnt == REPEAT_DELAY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
        end else if (!hold) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
        end else if (rpt_fire) begin
            rpt_cnt   <= 24'd1;
            rpt_armed <= 1'b1;
        end else begin
            rpt_cnt   <= rpt_cnt + 24'd1;
        end
    end

    assign inc_step = inc_press | (rpt_fire & level[1]);
    assign dec_step = dec_press | (rpt_fire & level[2]);
`else
    assign inc_step = inc_press;
    assign dec_step = dec_press;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            hour_q     <= '0;
            min_q      <= '0;
            sec_q      <= '0;
            time_out_q <= '0;
        end else begin
            state      <= state_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            time_out_q <= time_out_d;
        end
    end

    // Mode always takes priority over a same-cycle step.
    always_comb begin
        state_d    = state;
        hour_d     = hour_q;
        min_d      = min_q;
        sec_d      = sec_q;
        time_out_d = time_out_q;
        hour_step  = step_field({1'b0, hour_q}, 6'd23, inc_step, dec_step);
        min_step   = step_field(min_q, 6'd59, inc_step, dec_step);
        sec_step   = step_field(sec_q, 6'd59, inc_step, dec_step);
        case (state)
            S_IDLE: begin
                if (mode_press) begin
                    state_d = S_HOUR;
                    hour_d  = (cur_time[16:12] > 5'd23) ? 5'd0 : cur_time[16:12];
                    min_d   = (cur_time[11:6]  > 6'd59) ? 6'd0 : cur_time[11:6];
                    sec_d   = (cur_time[5:0]   > 6'd59) ? 6'd0 : cur_time[5:0];
                end
            end
            S_HOUR: begin
                if (mode_press) state_d = S_MIN;
                else            hour_d  = hour_step[4:0];
            end
            S_MIN: begin
                if (mode_press) state_d = S_SEC;
                else            min_d   = min_step;
            end
            S_SEC: begin
                if (mode_press) begin
                    state_d    = S_COMMIT;
                    time_out_d = {hour_q, min_q, sec_q};
                end else begin
                    sec_d = sec_step;
                end
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        editing    = 1'b0;
        edit_field = 2'd0;
        time_ow    = 1'b0;
        case (state)
            S_HOUR:   begin editing = 1'b1; edit_field = 2'd1; end
            S_MIN:    begin editing = 1'b1; edit_field = 2'd2; end
            S_SEC:    begin editing = 1'b1; edit_field = 2'd3; end
            S_COMMIT: time_ow = 1'b1;
            default:  ;
        endcase
    end

    assign time_out  = time_out_q;
    assign edit_time = {hour_q, min_q, sec_q};

endmodule

// File: tb/tb_time_setter.sv
// Self-checking bench for time_setter: directed scenarios plus randomized presses against a field-level model.
module tb_time_setter;

    localparam int D    = 4;
    localparam int HOLD = D + 6;
    localparam int GAP  = D + 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        btn_mode, btn_inc, btn_dec;
    logic [16:0] cur_time;
    logic [16:0] time_out;
    logic        time_ow;
    logic        editing;
    logic [1:0]  edit_field;
    logic [16:0] edit_time;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: field index 0=idle,1=hour,2=min,3=sec and integer time fields.
    int          m_field, m_h, m_m, m_s, m_commits;
    logic [16:0] m_out;

    int          ow_count = 0;
    int          to_violations = 0;
    logic [16:0] prev_to = '0;

    time_setter #(
        .DEBOUNCE_CYCLES(16'd4),
        .REPEAT_DELAY   (24'd20),
        .REPEAT_RATE    (24'd5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .btn_dec   (btn_dec),
        .cur_time  (cur_time),
        .time_out  (time_out),
        .time_ow   (time_ow),
        .editing   (editing),
        .edit_field(edit_field),
        .edit_time (edit_time)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (time_ow === 1'b1) ow_count++;
        if (rst_n === 1'b1 && time_ow !== 1'b1 && time_out !== prev_to) to_violations++;
        prev_to = time_out;
    end

    function automatic logic [16:0] pack(input int h, input int m, input int s);
        logic [4:0] hh;
        logic [5:0] mm, ss;
        hh = h[4:0];
        mm = m[5:0];
        ss = s[5:0];
        return {hh, mm, ss};
    endfunction

    task automatic model_reset();
        m_field = 0; m_h = 0; m_m = 0; m_s = 0; m_out = '0;
    endtask

    task automatic model_press(input bit mode, input bit inc, input bit dec);
        int d;
        if (mode) begin
            case (m_field)
                0: begin
                    m_h = int'(cur_time[16:12]); if (m_h > 23) m_h = 0;
                    m_m = int'(cur_time[11:6]);  if (m_m > 59) m_m = 0;
                    m_s = int'(cur_time[5:0]);   if (m_s > 59) m_s = 0;
                    m_field = 1;
                end
                1: m_field = 2;
                2: m_field = 3;
                default: begin
                    m_out = pack(m_h, m_m, m_s);
                    m_commits++;
                    m_field = 0;
                end
            endcase
        end else if ((inc ^ dec) && m_field != 0) begin
            d = inc ? 1 : -1;
            case (m_field)
                1: m_h = (m_h + d + 24) % 24;
                2: m_m = (m_m + d + 60) % 60;
                default: m_s = (m_s + d + 60) % 60;
            endcase
        end
    endtask

    task automatic press(input bit mode, input bit inc, input bit dec);
        @(posedge clk); #1;
        btn_mode = mode; btn_inc = inc; btn_dec = dec;
        repeat (HOLD) @(posedge clk);
        #1;
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        repeat (GAP) @(posedge clk);
        #1;
        model_press(mode, inc, dec);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; cur_time = '0;
        model_reset();
        m_commits = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (time_out !== 17'd0)  begin n_fail++; $display("FAIL reset_time_out: got %0h expected 0", time_out); end
        n_checks++; if (time_ow !== 1'b0)    begin n_fail++; $display("FAIL reset_time_ow: got %0b expected 0", time_ow); end
        n_checks++; if (editing !== 1'b0)    begin n_fail++; $display("FAIL reset_editing: got %0b expected 0", editing); end
        n_checks++; if (edit_field !== 2'd0) begin n_fail++; $display("FAIL reset_edit_field: got %0d expected 0", edit_field); end
        n_checks++; if (edit_time !== 17'd0) begin n_fail++; $display("FAIL reset_edit_time: got %0h expected 0", edit_time); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_capture();
        cur_time = pack(12, 34, 56);
        @(posedge clk); #1;
        btn_mode = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        n_checks++; if (editing !== 1'b0) begin n_fail++; $display("FAIL capture_too_early: got %0b expected 0", editing); end
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (editing !== 1'b1)    begin n_fail++; $display("FAIL capture_editing: got %0b expected 1", editing); end
        n_checks++; if (edit_field !== 2'd1) begin n_fail++; $display("FAIL capture_field: got %0d expected 1", edit_field); end
        n_checks++; if (edit_time !== pack(12, 34, 56)) begin n_fail++; $display("FAIL capture_time: got %0h expected %0h", edit_time, pack(12, 34, 56)); end
        repeat (HOLD - 7) @(posedge clk);
        #1; btn_mode = 1'b0;
        repeat (GAP) @(posedge clk);
        #1;
        model_press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++; if (time_out !== pack(12, 34, 56)) begin n_fail++; $display("FAIL capture_commit: got %0h expected %0h", time_out, pack(12, 34, 56)); end
    endtask

    task automatic test_wrap();
        int ow0;
        cur_time = pack(23, 0, 5);
        ow0 = ow_count;
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        n_checks++; if (edit_time !== pack(0, 0, 5)) begin n_fail++; $display("FAIL wrap_hour_inc: got %0h expected %0h", edit_time, pack(0, 0, 5)); end
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        n_checks++; if (edit_time !== pack(0, 59, 5)) begin n_fail++; $display("FAIL wrap_min_dec: got %0h expected %0h", edit_time, pack(0, 59, 5)); end
        n_checks++; if (edit_field !== 2'd2) begin n_fail++; $display("FAIL wrap_field: got %0d expected 2", edit_field); end
        n_checks++; if (ow_count !== ow0) begin n_fail++; $display("FAIL wrap_no_ow: got %0d strobes expected 0", ow_count - ow0); end
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_full_pass();
        int ow0;
        cur_time = pack(6, 58, 1);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        ow0 = ow_count;
        press(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++; if (ow_count - ow0 !== 1) begin n_fail++; $display("FAIL commit_ow_cycles: got %0d expected 1", ow_count - ow0); end
        n_checks++; if (time_out !== pack(7, 59, 0)) begin n_fail++; $display("FAIL commit_time_out: got %0h expected %0h", time_out, pack(7, 59, 0)); end
        n_checks++; if (editing !== 1'b0)    begin n_fail++; $display("FAIL commit_editing: got %0b expected 0", editing); end
        n_checks++; if (edit_field !== 2'd0) begin n_fail++; $display("FAIL commit_field: got %0d expected 0", edit_field); end
    endtask

    task automatic test_glitch_and_conflicts();
        cur_time = pack(3, 4, 5);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        btn_inc = 1'b1;
        repeat (3) @(posedge clk);
        #1; btn_inc = 1'b0;
        repeat (GAP) @(posedge clk);
        @(negedge clk);
        n_checks++; if (edit_time !== pack(3, 4, 5)) begin n_fail++; $display("FAIL glitch_ignored: got %0h expected %0h", edit_time, pack(3, 4, 5)); end
        press(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        n_checks++; if (edit_time !== pack(3, 4, 5)) begin n_fail++; $display("FAIL inc_dec_cancel: got %0h expected %0h", edit_time, pack(3, 4, 5)); end
        press(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        n_checks++; if (edit_field !== 2'd3) begin n_fail++; $display("FAIL mode_wins_field: got %0d expected 3", edit_field); end
        n_checks++; if (edit_time !== pack(3, 4, 5)) begin n_fail++; $display("FAIL mode_wins_time: got %0h expected %0h", edit_time, pack(3, 4, 5)); end
        press(1'b1, 1'b0, 1'b0);
        cur_time = pack(31, 60, 61);
        press(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++; if (edit_time !== 17'd0) begin n_fail++; $display("FAIL clamp_capture: got %0h expected 0", edit_time); end
        n_checks++; if (time_out !== pack(3, 4, 5)) begin n_fail++; $display("FAIL commit_after_conflicts: got %0h expected %0h", time_out, pack(3, 4, 5)); end
    endtask

    task automatic test_reset_mid_edit();
        int ow0;
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        ow0 = ow_count;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (editing !== 1'b0 || edit_field !== 2'd0) begin n_fail++; $display("FAIL midreset_ctrl: got editing=%0b field=%0d expected 0/0", editing, edit_field); end
        n_checks++; if (time_out !== 17'd0 || edit_time !== 17'd0 || time_ow !== 1'b0) begin n_fail++; $display("FAIL midreset_data: got out=%0h edit=%0h ow=%0b expected zeros", time_out, edit_time, time_ow); end
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1;
        model_reset();
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_checks++; if (ow_count !== ow0) begin n_fail++; $display("FAIL midreset_no_ow: got %0d strobes expected 0", ow_count - ow0); end
    endtask

    task automatic test_autorepeat();
        int exp_s;
        cur_time = pack(1, 2, 10);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        btn_inc = 1'b1;
        repeat (40) @(posedge clk);
        #1; btn_inc = 1'b0;
        repeat (GAP + 5) @(posedge clk);
`ifdef TIME_SETTER_AUTOREPEAT_EN
        exp_s = 15;
`else
        exp_s = 11;
`endif
        m_s = exp_s;
        @(negedge clk);
        n_checks++; if (edit_time !== pack(1, 2, exp_s)) begin n_fail++; $display("FAIL hold_inc_sec: got %0h expected %0h", edit_time, pack(1, 2, exp_s)); end
        press(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++; if (time_out !== pack(1, 2, exp_s)) begin n_fail++; $display("FAIL hold_commit: got %0h expected %0h", time_out, pack(1, 2, exp_s)); end
    endtask

    task automatic test_random();
        int kind;
        for (int i = 0; i < 40; i++) begin
            cur_time = 17'($urandom);
            kind = $urandom_range(0, 6);
            case (kind)
                0, 1: press(1'b1, 1'b0, 1'b0);
                2:    press(1'b0, 1'b1, 1'b0);
                3:    press(1'b0, 1'b0, 1'b1);
                4:    press(1'b0, 1'b1, 1'b1);
                5:    press(1'b1, 1'b1, 1'b0);
                default: press(1'b1, 1'b0, 1'b1);
            endcase
            @(negedge clk);
            n_checks++; if (edit_time !== pack(m_h, m_m, m_s)) begin n_fail++; $display("FAIL rand_edit_time[%0d]: got %0h expected %0h", i, edit_time, pack(m_h, m_m, m_s)); end
            n_checks++; if (edit_field !== 2'(m_field)) begin n_fail++; $display("FAIL rand_field[%0d]: got %0d expected %0d", i, edit_field, m_field); end
            n_checks++; if (time_out !== m_out) begin n_fail++; $display("FAIL rand_time_out[%0d]: got %0h expected %0h", i, time_out, m_out); end
        end
        n_checks++; if (ow_count !== m_commits) begin n_fail++; $display("FAIL ow_total: got %0d expected %0d", ow_count, m_commits); end
        n_checks++; if (to_violations !== 0) begin n_fail++; $display("FAIL out_without_ow: got %0d changes expected 0", to_violations); end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_wrap();
        test_full_pass();
        test_glitch_and_conflicts();
        test_reset_mid_edit();
        test_autorepeat();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/time_setter.md
# time_setter

Button-driven time-entry block that produces the packed time word and overwrite strobe consumed by the digital clock's `time_in`/`time_ow` port pair. It runs on the fast system clock and captures the clock's current time. It lets the user step hours, minutes and seconds with three push-buttons, then commits the edited value with a single-cycle overwrite pulse. It sits between the board buttons and the digital clock in the top level.

## Interface

**Parameters**
- `DEBOUNCE_CYCLES`, 16'd50000: consecutive stable synchronized samples required before a button level is accepted.
- `REPEAT_DELAY`, 24'd5000000: hold cycles before auto-repeat starts (only with macro).
- `REPEAT_RATE`, 24'd1000000: cycles between auto-repeat steps (only with macro).

**Ports**
- `clk` input 1: system clock, all logic on rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `btn_mode` input 1: raw, asynchronous mode button, active-high.
- `btn_inc` input 1: raw increment button, active-high.
- `btn_dec` input 1: raw decrement button, active-high.
- `cur_time` input 17: running time `{hour[4:0], min[5:0], sec[5:0]}`.
- `time_out` output 17: committed time, same packing; drives clock `time_in`.
- `time_ow` output 1: one-cycle overwrite strobe; drives clock `time_ow`.
- `editing` output 1: high in any edit state.
- `edit_field` output 2: 0 = none, 1 = hour, 2 = min, 3 = sec.
- `edit_time` output 17: working value being edited, same packing.

## Operation

**Button conditioning (per button)**
- 2-flop synchronizer feeds a debounce counter.
- The debounced level toggles only after the synchronized input differs from it for `DEBOUNCE_CYCLES` consecutive cycles.
- A rising edge of the debounced level produces a one-cycle press pulse.

**FSM states:** IDLE, HOUR, MIN, SEC, COMMIT.
- IDLE + mode press: capture `cur_time` into the edit registers, then go to HOUR.
  - A captured hour > 23 loads 0.
  - A captured min or sec > 59 loads 0.
- HOUR + mode press goes to MIN; MIN + mode press goes to SEC; SEC + mode press goes to COMMIT.
- COMMIT:
  - Load `time_out` from the edit registers.
  - Assert `time_ow`.
  - Go to IDLE unconditionally on the next cycle.
- In HOUR, MIN or SEC, an inc or dec press steps the selected field:
  - hour wraps 23→0 (inc) and 0→23 (dec);
  - min and sec wrap 59→0 and 0→59.
- Inc and dec press pulses in the same cycle: no change.
- A mode press in the same cycle as inc or dec: mode wins and the step is dropped.
- Inc/dec presses in IDLE or COMMIT are ignored.
- `edit_field` follows the state; `editing` = (state ∈ {HOUR, MIN, SEC}).
- `edit_time` holds its value in IDLE; it reflects the last edit or capture.

**Reset values**
- state = IDLE; `time_out` = 0; `time_ow` = 0; `editing` = 0; `edit_field` = 0; `edit_time` = 0.
- Synchronizers, debounced levels and counters clear to 0.
- A reset mid-edit discards the edit and produces no `time_ow`.

## Timing
- Raw button rising edge, then held stable: the press pulse is high in cycle 2 + `DEBOUNCE_CYCLES` after the first sampling edge. The state or field update is visible on the following edge.
- `time_ow` is high for exactly one `clk` cycle (the COMMIT cycle).
- `time_out` changes on the same edge that raises `time_ow` and holds until the next commit.
- `time_out` never changes without `time_ow`.
- Glitches shorter than `DEBOUNCE_CYCLES` cycles produce no pulse.
- Release bounce produces no pulse, because pulses come only from rising edges.

## Configuration
- Macro: `TIME_SETTER_AUTOREPEAT_EN`.
- **Defined:** holding debounced inc or dec in HOUR, MIN or SEC
  - after `REPEAT_DELAY` cycles generates one extra step,
  - then one step every `REPEAT_RATE` cycles until release or state change.
  - The repeat counter clears on release, on a mode press, and on reset.
- **Undefined:** exactly one step per press; the repeat counters and parameters are unused and not synthesized.

## Test plan
Bench uses `DEBOUNCE_CYCLES=4`, `REPEAT_DELAY=20`, `REPEAT_RATE=5`.

1. Reset, then `cur_time`=12:34:56, then one mode press → `editing`=1, `edit_field`=1, `edit_time`=12:34:56.
2. In HOUR with hour=23, one inc press → hour=0. Mode to MIN with min=0, one dec press → min=59. No `time_ow` during either step.
3. Full pass with edits to 07:59:00, then four mode presses → `time_ow` high exactly one cycle, `time_out`=07:59:00, state IDLE, `editing`=0.
4. A 3-cycle glitch on `btn_inc` in MIN → no change. Inc and dec pressed in the same cycle → no change. `cur_time`=31:60:61 captured → `edit_time`=00:00:00.
5. Assert `rst_n`=0 while in SEC → all outputs 0 immediately, `time_ow` never asserted.
6. With the macro defined: hold inc 40 cycles past debounce in SEC from 10 → sec=15 (1 press + 4 repeats). With the macro undefined → sec=11.
